spram_fifo_ctrl: RTL

- Streaming FIFO controller placed directly upstream of Single_Port_RAM.
- Accepts a valid/ready input stream and uses the RAM as FIFO storage (write via Data/Address/WE, read back via Output).
- Presents the data in order on a valid/ready output stream.
- The RAM has a single port, so the block issues at most one RAM access per cycle and arbitrates between writes and prefetch reads.

---
 rtl/spram_fifo_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/spram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// spram_fifo_ctrl : valid/ready FIFO that uses an external single-port RAM as
// storage, with prefetch into a 2-entry output buffer. Optional Almost_Full
// output is enabled by defining SPRAM_FIFO_ALMOST_FULL_EN.        Rev 1.0
// ============================================================================
module spram_fifo_ctrl #(
   parameter int IN_DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH         = 6,
   parameter int ALMOST_FULL_THRESH = 60
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [IN_DATA_WIDTH-1:0] In_Data,
   input  logic                     In_Valid,
   output logic                     In_Ready,
   output logic [IN_DATA_WIDTH-1:0] Out_Data,
   output logic                     Out_Valid,
   input  logic                     Out_Ready,
   output logic [IN_DATA_WIDTH-1:0] RAM_Data,
   output logic [ADDR_WIDTH-1:0]    RAM_Address,
   output logic                     RAM_WE,
   input  logic [IN_DATA_WIDTH-1:0] RAM_Output,
   output logic [ADDR_WIDTH+1:0]    Count
`ifdef SPRAM_FIFO_ALMOST_FULL_EN
   ,
   output logic                     Almost_Full
`endif
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int MC_W  = ADDR_WIDTH + 1;
   localparam int CNT_W = ADDR_WIDTH + 2;

   logic [ADDR_WIDTH-1:0]    wr_ptr;
   logic [ADDR_WIDTH-1:0]    rd_ptr;
   logic [MC_W-1:0]          mem_count;
   logic [MC_W-1:0]          mem_count_nx;
   logic                     rd_pend;
   logic [IN_DATA_WIDTH-1:0] ob0;
   logic [IN_DATA_WIDTH-1:0] ob1;
   logic [1:0]               ob_count;
   logic [1:0]               ob_count_nx;
   logic                     prio_wr;
   logic                     full;
   logic                     rd_want;
   logic                     conflict;
   logic                     wr_go;
   logic                     rd_go;
   logic                     pop;

   // A read is only worth issuing if its word has a guaranteed slot in ob.
   always_comb begin
      full     = (mem_count == MC_W'(DEPTH));
      rd_want  = (mem_count != '0) && ((ob_count + {1'b0, rd_pend}) < 2'd2);
      In_Ready = !RST && !full && (!rd_want || prio_wr);
      wr_go    = In_Valid && In_Ready;
      rd_go    = rd_want && !wr_go;
      conflict = In_Valid && !full && rd_want;
      pop      = (ob_count != 2'd0) && Out_Ready;
   end

   always_comb begin
      mem_count_nx = mem_count;
      if (wr_go) begin
         mem_count_nx = mem_count + MC_W'(1);
      end else if (rd_go) begin
         mem_count_nx = mem_count - MC_W'(1);
      end
      ob_count_nx = ob_count;
      if (rd_pend && !pop) begin
         ob_count_nx = ob_count + 2'd1;
      end else if (!rd_pend && pop) begin
         ob_count_nx = ob_count - 2'd1;
      end
   end

   assign RAM_WE      = wr_go;
   assign RAM_Data    = In_Data;
   assign RAM_Address = wr_go ? wr_ptr : rd_ptr;

   assign Out_Valid = (ob_count != 2'd0);
   assign Out_Data  = ob0;
   assign Count     = CNT_W'(mem_count) + CNT_W'(rd_pend) + CNT_W'(ob_count);

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         rd_pend   <= 1'b0;
         ob_count  <= 2'd0;
         ob0       <= '0;
         ob1       <= '0;
         prio_wr   <= 1'b0;
      end else begin
         mem_count <= mem_count_nx;
         ob_count  <= ob_count_nx;
         rd_pend   <= rd_go;
         if (wr_go) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (rd_go) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
         if (conflict) begin
            prio_wr <= !prio_wr;
         end
         // RAM_Output is valid only in the cycle after the read was issued.
         if (rd_pend && pop) begin
            if (ob_count == 2'd2) begin
               ob0 <= ob1;
               ob1 <= RAM_Output;
            end else begin
               ob0 <= RAM_Output;
            end
         end else if (pop) begin
            ob0 <= ob1;
         end else if (rd_pend) begin
            if (ob_count == 2'd0) begin
               ob0 <= RAM_Output;
            end else begin
               ob1 <= RAM_Output;
            end
         end
      end
   end

`ifdef SPRAM_FIFO_ALMOST_FULL_EN
   logic [CNT_W-1:0] count_nx;

   assign count_nx = CNT_W'(mem_count_nx) + CNT_W'(rd_go) + CNT_W'(ob_count_nx);

   always_ff @(posedge CLK) begin
      if (RST) begin
         Almost_Full <= 1'b0;
      end else begin
         Almost_Full <= (count_nx >= CNT_W'(ALMOST_FULL_THRESH));
      end
   end
`else
   logic unused_thresh;
   assign unused_thresh = (ALMOST_FULL_THRESH == 0);
`endif

endmodule
`default_nettype wire
